// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//                Holds the PC width, the NOP word used for bubbles, the
//                fetch state enum and the fetch-to-decode bundle type.
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  // Width of the program counter and of an instruction word.
  localparam int PC_W = 16;

  // Instruction word injected whenever IF/ID carries a bubble.
  localparam logic [PC_W-1:0] NOP_INSTR = 16'h0800;

  // Fetch state: running normally, or parked after a HALT until reset.
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  // Contents of the IF/ID pipeline register as seen by decode.
  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc_plus2;
    logic            valid;
  } fd_bundle_t;

  // Bubble value: NOP, zero link address, not valid.
  localparam fd_bundle_t FD_BUBBLE = '{
    instr:    NOP_INSTR,
    pc_plus2: '0,
    valid:    1'b0
  };

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PC_W-1:0] sat_inc(input logic [PC_W-1:0] v);
    return (&v) ? v : v + PC_W'(1);
  endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register. Loads a freshly fetched bundle,
//                holds its contents, or is flushed to a bubble. Flush and
//                reset take priority over hold, which takes priority over
//                load.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_reg
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       hold_i,
  input  logic       flush_i,
  input  fd_bundle_t d_i,
  output fd_bundle_t q_o
);

  fd_bundle_t bundle_q;

  // Bubble on reset/flush, otherwise keep or capture the new fetch.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      bundle_q <= FD_BUBBLE;
    end else if (hold_i) begin
      bundle_q <= bundle_q;
    end else if (load_i) begin
      bundle_q <= d_i;
    end
  end

  assign q_o = bundle_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch
//  Description : Instruction-fetch stage. Owns the program counter and the
//                IF/ID register; applies redirect, halt and stall requests
//                from downstream. Instruction memory is read combinationally
//                at imem_addr, which always mirrors the PC register.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [PC_W-1:0] imem_rd_data,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt_req,
  output logic [PC_W-1:0] instr,
  output logic [PC_W-1:0] pc_plus2,
  output logic            valid,
  output logic            halted,
  output logic [PC_W-1:0] fetch_count,
  output logic            err
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            halted_q;
  logic [PC_W-1:0] count_q;

  // --------------------------------------------------------------------------
  // Request decode. In RUN the order is redirect > halt > stall > fetch;
  // in HALTED every request is ignored and everything freezes.
  // --------------------------------------------------------------------------
  logic            w_run;
  logic            w_redirect;
  logic            w_halt;
  logic            w_stall;
  logic            w_fetch;
  logic [PC_W-1:0] w_pc_plus2;

  assign w_run      = (state_q == ST_RUN);
  assign w_redirect = w_run & redirect;
  assign w_halt     = w_run & ~redirect & halt_req;
  assign w_stall    = w_run & ~redirect & ~halt_req & stall;
  assign w_fetch    = w_run & ~redirect & ~halt_req & ~stall;

  // Natural 16-bit wrap: 16'hFFFE + 2 becomes 16'h0000.
  assign w_pc_plus2 = pc_q + PC_W'(2);

  // Next PC: redirect target, sequential address, or hold.
  always_comb begin
    pc_d = pc_q;
    if (w_redirect) begin
      pc_d = redirect_pc;
    end else if (w_fetch) begin
      pc_d = w_pc_plus2;
    end
  end

  // PC, run/halt state, halted flag and fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_RUN;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        ST_RUN: begin
          if (w_halt) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end
          if (w_fetch) begin
            count_q <= sat_inc(count_q);
          end
        end
        ST_HALTED: begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= ST_RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // IF/ID register. While HALTED it already holds a bubble, so a hold keeps
  // it that way.
  // --------------------------------------------------------------------------
  fd_bundle_t w_fd_d;
  fd_bundle_t w_fd_q;

  assign w_fd_d = '{instr: imem_rd_data, pc_plus2: w_pc_plus2, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_fetch),
    .hold_i  (~w_run | w_stall),
    .flush_i (w_redirect | w_halt),
    .d_i     (w_fd_d),
    .q_o     (w_fd_q)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr   = pc_q;
  assign instr       = w_fd_q.instr;
  assign pc_plus2    = w_fd_q.pc_plus2;
  assign valid       = w_fd_q.valid;
  assign halted      = halted_q;
  assign fetch_count = count_q;

  // An odd redirect target is flagged but still loaded unchanged. Unknown
  // inputs are flagged as well so that a broken upstream is visible.
  assign err = (redirect & redirect_pc[0]) |
               $isunknown({rst, imem_rd_data, stall, redirect, redirect_pc, halt_req});

endmodule : fetch
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch
//  Description : Self-checking bench for the fetch stage. Directed sequences
//                followed by randomized requests, all compared against a
//                cycle-level reference model of the fetch rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_rd_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic [15:0] instr;
  logic [15:0] pc_plus2;
  logic        valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic        err;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_p2;
  logic        m_valid;
  logic        m_halted;
  logic [15:0] m_cnt;

  fetch #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rd_data (imem_rd_data),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt_req     (halt_req),
    .instr        (instr),
    .pc_plus2     (pc_plus2),
    .valid        (valid),
    .halted       (halted),
    .fetch_count  (fetch_count),
    .err          (err)
  );

  assign imem_rd_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the architectural rules, using the inputs held at the edge.
  task automatic model_edge();
    if (rst) begin
      m_pc = 16'h0000; m_instr = 16'h0800; m_p2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0000;
    end else if (m_halted) begin
      // frozen
    end else if (redirect) begin
      m_pc = redirect_pc; m_instr = 16'h0800; m_p2 = 16'h0000; m_valid = 1'b0;
    end else if (halt_req) begin
      m_instr = 16'h0800; m_p2 = 16'h0000; m_valid = 1'b0; m_halted = 1'b1;
    end else if (stall) begin
      // hold
    end else begin
      m_instr = mem[m_pc];
      m_pc    = m_pc + 16'd2;
      m_p2    = m_pc;
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic check_all();
    check("imem_addr",   imem_addr,   m_pc);
    check("instr",       instr,       m_instr);
    check("pc_plus2",    pc_plus2,    m_p2);
    check("valid",       {15'd0, valid},  {15'd0, m_valid});
    check("halted",      {15'd0, halted}, {15'd0, m_halted});
    check("fetch_count", fetch_count, m_cnt);
    check("err",         {15'd0, err},    {15'd0, redirect & redirect_pc[0]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  logic [15:0] saved_pc;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[2] = 16'h2222; mem[4] = 16'h3333;
    mem[16'h0040] = 16'hABCD;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt_req = 1'b0;
    #1;
    step(); step();
    check("rst_instr", instr, 16'h0800);
    check("rst_addr",  imem_addr, 16'h0000);

    // sequential fetch after reset release
    rst = 1'b0;
    step();
    check("seq1_instr", instr, 16'h1111); check("seq1_p2", pc_plus2, 16'd2);
    check("seq1_cnt", fetch_count, 16'd1); check("seq1_addr", imem_addr, 16'd2);
    step();
    check("seq2_instr", instr, 16'h2222); check("seq2_cnt", fetch_count, 16'd2);
    step();
    check("seq3_instr", instr, 16'h3333); check("seq3_p2", pc_plus2, 16'd6);

    // stall for three cycles after the first fetch
    rst = 1'b1; step(); rst = 1'b0; step();
    stall = 1'b1;
    repeat (3) begin
      step();
      check("stall_instr", instr, 16'h1111);
      check("stall_addr",  imem_addr, 16'd2);
    end
    stall = 1'b0;
    step();
    check("post_stall_instr", instr, 16'h2222);

    // redirect wins over stall
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    step();
    check("redir_valid", {15'd0, valid}, 16'd0);
    check("redir_instr", instr, 16'h0800);
    check("redir_addr",  imem_addr, 16'h0040);
    redirect = 1'b0; stall = 1'b0;
    step();
    check("redir_target", instr, 16'hABCD);

    // halt, then ignored redirects, then reset
    halt_req = 1'b1;
    step();
    check("halt_flag",  {15'd0, halted}, 16'd1);
    check("halt_valid", {15'd0, valid},  16'd0);
    halt_req = 1'b0;
    saved_pc = imem_addr;
    redirect = 1'b1; redirect_pc = 16'h0100;
    repeat (5) begin
      step();
      check("halt_frozen_pc", imem_addr, saved_pc);
    end
    redirect = 1'b0; rst = 1'b1;
    step();
    check("halt_rst_addr",   imem_addr, 16'h0000);
    check("halt_rst_halted", {15'd0, halted}, 16'd0);
    rst = 1'b0;
    step();

    // halt request squashed by simultaneous redirect
    halt_req = 1'b1; redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    check("squash_halted", {15'd0, halted}, 16'd0);
    check("squash_addr",   imem_addr, 16'h0010);
    halt_req = 1'b0; redirect = 1'b0;
    step();

    // misaligned redirect
    redirect = 1'b1; redirect_pc = 16'h0013;
    #1;
    check("odd_err", {15'd0, err}, 16'd1);
    step();
    check("odd_addr", imem_addr, 16'h0013);
    redirect = 1'b0;
    step();

    // PC wrap
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    step();
    check("wrap_addr", imem_addr, 16'h0000);
    check("wrap_p2",   pc_plus2,  16'h0000);

    // randomized requests
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) < 2);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_pc = 16'($urandom);
      if ($urandom_range(0, 7) != 0) redirect_pc[0] = 1'b0;
      halt_req = ($urandom_range(0, 29) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_fetch
`default_nettype wire
